// File: rtl/mac_seq.sv
// Operand sequencer for one signed 8x8 MAC dot product: clears the MAC, walks the
// operand memories, then activates (ReLU, shift, saturate) the final sum into result.
module mac_seq #(
    parameter int N_TERMS   = 784,
    parameter int ADDR_W    = 10,
    parameter int RES_SHIFT = 7
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic signed [7:0]        in_data,
    input  logic signed [7:0]        wt_data,
    input  logic signed [25:0]       mac_acc,
    output logic        [ADDR_W-1:0] addr,
    output logic signed [7:0]        mac_a,
    output logic signed [7:0]        mac_b,
    output logic                     mac_clr_n,
    output logic        [7:0]        result,
    output logic                     busy,
    output logic                     done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_ACCUM = 3'd2,
        S_DRAIN = 3'd3,
        S_WB    = 3'd4
    } state_t;

    // One spare bit so the count can reach N_TERMS even when N_TERMS == 2**ADDR_W.
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             term_vld_q, term_vld_d;
    logic [7:0]       result_q, result_d;
    logic             done_q, done_d;

    function automatic logic [7:0] activate(input logic signed [25:0] acc);
        logic signed [25:0] shifted;
        shifted = acc >>> RES_SHIFT;
        if (acc < 26'sd0) begin
            activate = 8'h00;
        end else if (shifted > 26'sd255) begin
            activate = 8'hFF;
        end else begin
            activate = shifted[7:0];
        end
    endfunction

    // State, counter and result registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= {CNT_W{1'b0}};
            term_vld_q <= 1'b0;
            result_q   <= 8'h00;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            term_vld_q <= term_vld_d;
            result_q   <= result_d;
            done_q     <= done_d;
        end
    end

    // Next-state logic; term_vld marks the cycle after an address was issued.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        term_vld_d = 1'b0;
        result_d   = result_q;
        done_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLR;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CLR: begin
                cnt_d      = CNT_W'(1);
                term_vld_d = 1'b1;
                state_d    = S_ACCUM;
            end
            S_ACCUM: begin
                cnt_d      = cnt_q + CNT_W'(1);
                term_vld_d = 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_ACCUM;
                end
            end
            S_DRAIN: begin
                state_d = S_WB;
            end
            S_WB: begin
                result_d = activate(mac_acc);
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Operand steering: a zero product keeps the MAC unchanged outside valid terms.
    always_comb begin
        if (term_vld_q) begin
            mac_a = in_data;
            mac_b = wt_data;
        end else begin
            mac_a = 8'sd0;
            mac_b = 8'sd0;
        end
    end

    assign addr      = cnt_q[ADDR_W-1:0];
    assign mac_clr_n = (state_q != S_CLR);
    assign busy      = (state_q != S_IDLE);
    assign result    = result_q;
    assign done      = done_q;

endmodule
